opl3_host_wr_gen: RTL and testbench

Host-side producer of the `opl3_reg_wr` stream consumed by `channels` and the other register-file clients. It turns byte-wide host port accesses into `opl3_reg_wr_t` write beats:
- address port, then data port;
- OPL3 bank-select rules.

It buffers host bursts in a small FIFO and paces output beats. After every reset it first emits a full register-clear sweep of both banks, so downstream state never depends on what the previous program left behind.

---
 rtl/opl3_host_wr_gen_if.sv | 32 +++
 rtl/opl3_host_wr_gen.sv | 178 +++++++++++++++++
 tb/tb_opl3_host_wr_gen.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/opl3_host_wr_gen_if.sv
// Host-port / register-write bus bundle for opl3_host_wr_gen.
//   host_wr     : one-cycle write strobe                      (host -> gen)
//   host_rd     : one-cycle status-read strobe                (host -> gen)
//   host_addr   : [1] bank port select, [0] 0=address 1=data  (host -> gen)
//   host_din    : write data                                  (host -> gen)
//   host_dout   : status {busy, fifo_full, overflow, 5'b0}    (gen -> host)
//   opl3_reg_wr : {valid, bank_num, address, data} beat       (gen -> clients)
interface opl3_host_wr_gen_if;
    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

    logic         host_wr;
    logic         host_rd;
    logic [1:0]   host_addr;
    logic [7:0]   host_din;
    logic [7:0]   host_dout;
    opl3_reg_wr_t opl3_reg_wr;

    modport master (
        output host_wr, host_rd, host_addr, host_din,
        input  host_dout, opl3_reg_wr
    );

    modport slave (
        input  host_wr, host_rd, host_addr, host_din,
        output host_dout, opl3_reg_wr
    );
endinterface

// File: rtl/opl3_host_wr_gen.sv
// Host-side producer of the opl3_reg_wr register-write stream.
// Address/data port accesses are turned into {bank, address, data} entries,
// buffered in a FIFO and emitted as paced one-cycle beats. After reset a
// 512-write clear sweep of both banks runs before any host entry is drained.
// Ports:
//   clk   : single clock
//   reset : synchronous, active-high
//   bus   : slave side of opl3_host_wr_gen_if (host strobes/data, status,
//           registered opl3_reg_wr beat output)
module opl3_host_wr_gen #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned MIN_WR_SPACING = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic               clk,
    input logic               reset,
    opl3_host_wr_gen_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (MIN_WR_SPACING > 1) ? $clog2(MIN_WR_SPACING) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_WR_SPACING - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        GAP
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    state_t        state;
    state_t        state_nxt;

    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [7:0]    lat_addr;
    logic          lat_bank;
    logic          new_mode;
    logic          overflow;
    logic [8:0]    clr_idx;
    logic [GW-1:0] gap_cnt;
    logic [17:0]   out_q;
    logic [7:0]    dout_q;

    logic          push_req;
    logic          push_ok;
    logic          push_drop;
    logic          fifo_full;
    logic          busy;
    logic          spacing_ok;
    logic          pop;
    logic          emit;
    logic [16:0]   push_entry;
    logic [16:0]   head;
    logic [16:0]   emit_entry;

    assign push_req   = bus.host_wr & bus.host_addr[0];
    assign fifo_full  = (count == FULL_COUNT);
    assign push_ok    = push_req & ~fifo_full;
    assign push_drop  = push_req & fifo_full;
    assign push_entry = {lat_bank, lat_addr, bus.host_din};
    assign spacing_ok = (gap_cnt == '0);
    assign busy       = (state != IDLE) || (count != '0);

    // With an empty FIFO the incoming entry is written to the slot at rd_ptr
    // and popped in the same cycle, giving single-cycle write-to-beat latency.
    assign head = (count == '0) ? push_entry : mem[rd_ptr];

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        emit       = 1'b0;
        emit_entry = '0;
        unique case (state)
            CLEAR: begin
                if (spacing_ok) begin
                    emit       = 1'b1;
                    emit_entry = {clr_idx[8], clr_idx[7:0], 8'h00};
                    if (clr_idx == 9'h1FF) begin
                        state_nxt = IDLE;
                    end
                end
            end
            IDLE: begin
                if (spacing_ok && ((count != '0) || push_ok)) begin
                    pop        = 1'b1;
                    emit       = 1'b1;
                    emit_entry = head;
                    if (MIN_WR_SPACING > 1) begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= GW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RESET_STATE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lat_addr <= '0;
            lat_bank <= 1'b0;
            new_mode <= 1'b0;
            overflow <= 1'b0;
            clr_idx  <= '0;
            gap_cnt  <= '0;
            out_q    <= '0;
            dout_q   <= '0;
        end else begin
            state <= state_nxt;

            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (bus.host_wr && !bus.host_addr[0]) begin
                lat_addr <= bus.host_din;
                lat_bank <= bus.host_addr[1] & (new_mode | (bus.host_din == 8'h05));
            end
            if (push_ok && lat_bank && (lat_addr == 8'h05)) begin
                new_mode <= bus.host_din[0];
            end

            if (emit && (state == CLEAR)) begin
                clr_idx <= clr_idx + 9'd1;
            end

            if (emit) begin
                gap_cnt <= GAP_RELOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            out_q <= emit ? {1'b1, emit_entry} : '0;

            // Status is captured before this cycle's push; a drop in the same
            // cycle as a read keeps overflow set for the next read.
            if (bus.host_rd) begin
                dout_q <= {busy, fifo_full, overflow, 5'b0};
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (bus.host_rd) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.opl3_reg_wr = out_q;
    assign bus.host_dout   = dout_q;
endmodule

// File: tb/tb_opl3_host_wr_gen.sv
// Bench for opl3_host_wr_gen: two instances (spacing 1 and spacing 4) share
// the same host stimulus and are compared every cycle against a queue-based
// behavioural model, with literal pins on key beats and status reads.
module tb_opl3_host_wr_gen;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       h_wr, h_rd;
    logic [1:0] h_addr;
    logic [7:0] h_din;

    opl3_host_wr_gen_if b1 ();
    opl3_host_wr_gen_if b4 ();

    assign b1.host_wr = h_wr;  assign b1.host_rd = h_rd;
    assign b1.host_addr = h_addr;  assign b1.host_din = h_din;
    assign b4.host_wr = h_wr;  assign b4.host_rd = h_rd;
    assign b4.host_addr = h_addr;  assign b4.host_din = h_din;

    opl3_host_wr_gen #(.FIFO_DEPTH(16), .MIN_WR_SPACING(1), .CLEAR_ON_RESET(1'b1))
        dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    opl3_host_wr_gen #(.FIFO_DEPTH(16), .MIN_WR_SPACING(4), .CLEAR_ON_RESET(1'b1))
        dut4 (.clk(clk), .reset(reset), .bus(b4.slave));

    logic [17:0] o1, o4;
    assign o1 = b1.opl3_reg_wr;
    assign o4 = b4.opl3_reg_wr;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    endtask

    function automatic int sp(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Behavioural model state, index 0 = spacing 1, index 1 = spacing 4.
    logic [16:0] m_buf [2][DEPTH];
    int          m_head [2];
    int          m_size [2];
    int          m_sweep [2];
    int          m_wait [2];
    bit          m_gapsrc [2];
    bit          m_ovf [2];
    bit          m_newmode [2];
    logic [7:0]  m_laddr [2];
    bit          m_lbank [2];
    logic [17:0] m_out [2];
    logic [7:0]  m_dout [2];
    bit          m_rdchk [2];
    bit          live = 1'b0;
    int          cyc = 0;

    always @(posedge clk) begin : model
        int sz0;
        bit busy;
        bit drop;
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                live = 1'b1;
                m_head[k] = 0; m_size[k] = 0; m_sweep[k] = 0; m_wait[k] = 0;
                m_gapsrc[k] = 0; m_ovf[k] = 0; m_newmode[k] = 0;
                m_laddr[k] = 8'h00; m_lbank[k] = 0;
                m_out[k] = '0; m_dout[k] = 8'h00; m_rdchk[k] = 0;
            end else begin
                sz0  = m_size[k];
                busy = (m_sweep[k] < 512) || (sz0 != 0) || ((m_wait[k] != 0) && m_gapsrc[k]);
                m_rdchk[k] = h_rd;
                if (h_rd) m_dout[k] = {busy, sz0 == DEPTH, m_ovf[k], 5'b0};
                drop = 0;
                if (h_wr && !h_addr[0]) begin
                    m_laddr[k] = h_din;
                    m_lbank[k] = h_addr[1] && (m_newmode[k] || h_din == 8'h05);
                end
                if (h_wr && h_addr[0]) begin
                    if (sz0 < DEPTH) begin
                        m_buf[k][(m_head[k] + m_size[k]) % DEPTH] = {m_lbank[k], m_laddr[k], h_din};
                        m_size[k]++;
                        if (m_lbank[k] && m_laddr[k] == 8'h05) m_newmode[k] = h_din[0];
                    end else begin
                        drop = 1;
                    end
                end
                if (drop) m_ovf[k] = 1;
                else if (h_rd) m_ovf[k] = 0;
                m_out[k] = '0;
                if (m_wait[k] != 0) begin
                    m_wait[k]--;
                end else if (m_sweep[k] < 512) begin
                    m_out[k] = {1'b1, 9'(m_sweep[k]), 8'h00};
                    m_sweep[k]++;
                    m_wait[k] = sp(k) - 1;
                    m_gapsrc[k] = 0;
                end else if (m_size[k] != 0) begin
                    m_out[k] = {1'b1, m_buf[k][m_head[k]]};
                    m_head[k] = (m_head[k] + 1) % DEPTH;
                    m_size[k]--;
                    m_wait[k] = sp(k) - 1;
                    m_gapsrc[k] = 1;
                end
            end
        end
    end

    logic [17:0] lb1 [$];
    logic [17:0] lb4 [$];
    int          lc1 [$];
    int          lc4 [$];

    always @(negedge clk) begin
        if (live) begin
            check("dut1.opl3_reg_wr", 32'(o1), 32'(m_out[0]));
            check("dut4.opl3_reg_wr", 32'(o4), 32'(m_out[1]));
            if (m_rdchk[0]) check("dut1.host_dout", 32'(b1.host_dout), 32'(m_dout[0]));
            if (m_rdchk[1]) check("dut4.host_dout", 32'(b4.host_dout), 32'(m_dout[1]));
            if (o1[17]) begin lb1.push_back(o1); lc1.push_back(cyc); end
            if (o4[17]) begin lb4.push_back(o4); lc4.push_back(cyc); end
        end
    end

    task automatic io(input bit wr, input bit rd, input logic [1:0] a, input logic [7:0] d);
        h_wr = wr; h_rd = rd; h_addr = a; h_din = d;
        @(posedge clk); #1;
        h_wr = 0; h_rd = 0; h_addr = 2'b00; h_din = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_logs(input int t1, input int t4, input string name);
        int guard = 0;
        while ((lb1.size() < t1 || lb4.size() < t4) && guard < 5000) begin
            @(posedge clk); #1; guard++;
        end
        check(name, 32'(lb1.size() >= t1 && lb4.size() >= t4), 32'd1);
    endtask

    initial begin : stim
        bit ok;
        int n1, n4, m1, m4;
        h_wr = 0; h_rd = 0; h_addr = 2'b00; h_din = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_out_zero", 32'(o1), 32'd0);

        // Overflow during the sweep: 17 pushes into a 16-deep FIFO.
        idle(10);
        io(0, 1, 2'b00, 8'h00);
        check("status_busy_in_sweep", 32'(b1.host_dout), 32'h80);
        io(1, 0, 2'b00, 8'h20);
        for (int i = 0; i < 17; i++) io(1, 0, 2'b01, 8'(i));
        io(0, 1, 2'b00, 8'h00);
        check("status_overflow_set", 32'(b1.host_dout), 32'hE0);
        io(0, 1, 2'b00, 8'h00);
        check("status_overflow_cleared", 32'(b1.host_dout), 32'hC0);

        wait_logs(528, 528, "sweep_drain_timeout");
        idle(10);
        check("sweep_first_beat", 32'(lb1[0]), 32'h20000);
        check("sweep_last_beat", 32'(lb1[511]), 32'h3FF00);
        ok = (lb1.size() >= 528);
        for (int i = 0; i < 512 && ok; i++)
            if (lb1[i] !== {1'b1, 9'(i), 8'h00} || (i > 0 && lc1[i] != lc1[i-1] + 1)) ok = 0;
        check("sweep_seq_consecutive", 32'(ok), 32'd1);
        ok = (lb1.size() == 528) && (lb4.size() == 528);
        for (int i = 0; i < 16 && ok; i++)
            if (lb1[512+i] !== 18'h22000 + 18'(i) || lb4[512+i] !== 18'h22000 + 18'(i)) ok = 0;
        check("fifo_16_in_order_17th_dropped", 32'(ok), 32'd1);
        io(0, 1, 2'b00, 8'h00);
        check("status_idle_dut1", 32'(b1.host_dout), 32'h00);
        check("status_idle_dut4", 32'(b4.host_dout), 32'h00);

        // OPL2 mode then switch to OPL3 via bank 1 reg 0x05.
        io(1, 0, 2'b10, 8'hC0);
        io(1, 0, 2'b11, 8'h31);
        check("opl2_beat_latency", 32'(o1), 32'h2C031);
        idle(5);
        io(1, 0, 2'b10, 8'h05);
        io(1, 0, 2'b11, 8'h01);
        check("new_mode_beat", 32'(o1), 32'h30501);
        idle(5);
        io(1, 0, 2'b10, 8'hC0);
        io(1, 0, 2'b11, 8'h30);
        check("opl3_bank1_beat", 32'(o1), 32'h3C030);
        idle(5);

        // Back-to-back data writes: spacing 4 paces them, order preserved.
        io(1, 0, 2'b00, 8'h40);
        n1 = lb1.size(); n4 = lb4.size();
        for (int i = 0; i < 6; i++) io(1, 0, 2'b01, 8'h50 + 8'(i));
        idle(40);
        ok = (lb4.size() == n4 + 6) && (lb1.size() == n1 + 6);
        for (int i = 0; i < 6 && ok; i++) begin
            if (lb4[n4+i] !== 18'h24050 + 18'(i)) ok = 0;
            if (i > 0 && lc4[n4+i] != lc4[n4+i-1] + 4) ok = 0;
            if (i > 0 && lc1[n1+i] != lc1[n1+i-1] + 1) ok = 0;
        end
        check("spacing4_six_beats", 32'(ok), 32'd1);

        // Randomized host traffic.
        for (int i = 0; i < 400; i++) begin
            h_wr   = ($urandom_range(0, 99) < 45);
            h_rd   = ($urandom_range(0, 4) == 0);
            h_addr = 2'($urandom_range(0, 3));
            if (!h_addr[0]) begin
                case ($urandom_range(0, 3))
                    0: h_din = 8'h05;
                    1: h_din = 8'hC0;
                    2: h_din = 8'h20;
                    default: h_din = 8'($urandom);
                endcase
            end else begin
                h_din = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        h_wr = 0; h_rd = 0; h_addr = 2'b00; h_din = 8'h00;
        idle(150);

        // Reset mid-sweep with three FIFO entries pending.
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        n1 = lb1.size(); n4 = lb4.size();
        wait_logs(n1 + 90, 0, "midsweep_wait_timeout");
        io(1, 0, 2'b00, 8'h10);
        io(1, 0, 2'b01, 8'hA1);
        io(1, 0, 2'b01, 8'hA2);
        io(1, 0, 2'b01, 8'hA3);
        wait_logs(n1 + 100, 0, "midsweep_beat100_timeout");
        reset = 1'b1;
        idle(1);
        check("reset_cycle_out_zero", 32'(o1), 32'd0);
        reset = 1'b0;
        m1 = lb1.size(); m4 = lb4.size();
        wait_logs(m1 + 512, m4 + 512, "resweep_timeout");
        idle(40);
        check("resweep_first_beat_dut1", 32'(lb1[m1]), 32'h20000);
        check("resweep_first_beat_dut4", 32'(lb4[m4]), 32'h20000);
        ok = (lb1.size() == m1 + 512) && (lb4.size() == m4 + 512);
        for (int i = m1; i < lb1.size(); i++)
            if (lb1[i][7:0] inside {8'hA1, 8'hA2, 8'hA3}) ok = 0;
        for (int i = m4; i < lb4.size(); i++)
            if (lb4[i][7:0] inside {8'hA1, 8'hA2, 8'hA3}) ok = 0;
        check("flushed_entries_never_emitted", 32'(ok), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
